fetch_execute_controller: RTL

//  Sequencer for the simple processor datapath: fetches 8-bit instructions (opcode[7:4], operando[3:0])

---
 rtl/fetch_execute_controller_pkg.sv | 43 ++++
 rtl/fetch_execute_controller_decoder.sv | 30 +++
 rtl/fetch_execute_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_execute_controller_pkg.sv
// Shared definitions for the fetch/execute sequencer: widths, opcodes, FSM state
// encodings and the instruction class reported by the decoder.
package fetch_execute_controller_pkg;

    localparam int FEC_DATA_W = 8;
    localparam int FEC_ADDR_W = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Encodings are visible on the debug LEDs, so keep them stable.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEM_RD = 4'd3,
        ST_LOAD   = 4'd4,
        ST_MEM_WR = 4'd5,
        ST_ALU    = 4'd6,
        ST_ALU_WB = 4'd7,
        ST_PAUSE  = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    // Jumps and illegal opcodes are CLS_NOP: they finish in DECODE.
    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_LOAD,
        CLS_STORE,
        CLS_ALU,
        CLS_HALT
    } op_class_e;

endpackage

// File: rtl/fetch_execute_controller_decoder.sv
// Combinational instruction decoder: opcode nibble -> instruction class,
// jump decision (JZ uses the current zero flag) and illegal-opcode flag.
module fetch_execute_controller_decoder
    import fetch_execute_controller_pkg::*;
(
    input  logic [7:0] instr,
    input  logic       zero,
    output op_class_e  op_class,
    output logic       jump,
    output logic       illegal
);

    // Classify the opcode; A-E fall through to illegal and behave as NOP.
    always_comb begin
        op_class = CLS_NOP;
        jump     = 1'b0;
        illegal  = 1'b0;
        case (instr[7:4])
            OP_NOP:                         op_class = CLS_NOP;
            OP_LDA, OP_LDB:                 op_class = CLS_LOAD;
            OP_STA:                         op_class = CLS_STORE;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  op_class = CLS_ALU;
            OP_JMP:                         jump     = 1'b1;
            OP_JZ:                          jump     = zero;
            OP_HLT:                         op_class = CLS_HALT;
            default:                        illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_execute_controller.sv
// Fetch/decode/execute sequencer for the 8-bit datapath. Owns PC, A, B, the
// zero flag and the sticky illegal flag; drives the RAM and ULA with one-cycle
// registered strobes.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   FETCH  | mem_rd at pc
//   DECODE | latch opcode, advance or redirect pc, pick execute path
//   MEM_RD | mem_rd at operand (LDA/LDB)
//   LOAD   | A or B <= mem_rdata
//   MEM_WR | mem_we at operand with A (STA)
//   ALU    | alu_enable with opcode
//   ALU_WB | A <= alu_result, update zero
//   PAUSE  | single-step wait for step/start
//   HALT   | stopped by HLT, registers retained
//
// "END" is not a state: every instruction's last state picks PAUSE or FETCH
// directly from step_mode.
module fetch_execute_controller
    import fetch_execute_controller_pkg::*;
#(
    parameter int DATA_W = FEC_DATA_W,
    parameter int ADDR_W = FEC_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        alu_opcode,
    output logic              alu_enable,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        state,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] reg_a_q, reg_a_d;
    logic [DATA_W-1:0] reg_b_q, reg_b_d;
    // Only the opcode half of IR is kept; the operand is consumed in DECODE.
    logic [3:0]        ir_op_q, ir_op_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        alu_opcode_q, alu_opcode_d;
    logic              alu_enable_q, alu_enable_d;

    logic [7:0]        instr;
    logic [ADDR_W-1:0] operand;
    op_class_e         dec_class;
    logic              dec_jump;
    logic              dec_illegal;
    state_e            end_next;

    assign instr    = mem_rdata[7:0];
    assign operand  = mem_rdata[ADDR_W-1:0];
    assign end_next = step_mode ? ST_PAUSE : ST_FETCH;

    fetch_execute_controller_decoder u_decoder (
        .instr    (instr),
        .zero     (zero_q),
        .op_class (dec_class),
        .jump     (dec_jump),
        .illegal  (dec_illegal)
    );

    // Next-state, register updates and next-cycle strobe values.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        reg_a_d      = reg_a_q;
        reg_b_d      = reg_b_q;
        ir_op_d      = ir_op_q;
        zero_d       = zero_q;
        illegal_d    = illegal_q;
        mem_addr_d   = mem_addr_q;
        alu_opcode_d = alu_opcode_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ir_op_d = instr[7:4];
                pc_d    = dec_jump ? operand : pc_q + 1'b1;
                if (dec_illegal) illegal_d = 1'b1;
                case (dec_class)
                    CLS_LOAD:  state_d = ST_MEM_RD;
                    CLS_STORE: state_d = ST_MEM_WR;
                    CLS_ALU:   state_d = ST_ALU;
                    CLS_HALT:  state_d = ST_HALT;
                    default:   state_d = end_next;
                endcase
            end
            ST_MEM_RD: state_d = ST_LOAD;
            ST_LOAD: begin
                if (ir_op_q == OP_LDB) reg_b_d = mem_rdata;
                else                   reg_a_d = mem_rdata;
                state_d = end_next;
            end
            ST_MEM_WR: state_d = end_next;
            ST_ALU:    state_d = ST_ALU_WB;
            ST_ALU_WB: begin
                reg_a_d = alu_result;
                zero_d  = (alu_result == '0);
                state_d = end_next;
            end
            ST_PAUSE: begin
                // start wins over step: restart from address 0.
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end else if (step) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are decided from the state being entered so they are flops.
        mem_rd_d     = (state_d == ST_FETCH) || (state_d == ST_MEM_RD);
        mem_we_d     = (state_d == ST_MEM_WR);
        alu_enable_d = (state_d == ST_ALU);
        if (state_d == ST_FETCH) begin
            mem_addr_d = pc_d;
        end else if ((state_d == ST_MEM_RD) || (state_d == ST_MEM_WR)) begin
            mem_addr_d = operand;
        end
        if (state_d == ST_ALU) alu_opcode_d = instr[7:4];
    end

    // FSM and datapath registers; reset clears strobes asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            reg_a_q      <= '0;
            reg_b_q      <= '0;
            ir_op_q      <= '0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            alu_opcode_q <= '0;
            alu_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            reg_a_q      <= reg_a_d;
            reg_b_q      <= reg_b_d;
            ir_op_q      <= ir_op_d;
            zero_q       <= zero_d;
            illegal_q    <= illegal_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            mem_we_q     <= mem_we_d;
            alu_opcode_q <= alu_opcode_d;
            alu_enable_q <= alu_enable_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = reg_a_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_enable = alu_enable_q;
    assign reg_a      = reg_a_q;
    assign reg_b      = reg_b_q;
    assign pc         = pc_q;
    assign state      = state_q;
    assign busy       = !(state_q inside {ST_IDLE, ST_HALT, ST_PAUSE});
    assign halted     = (state_q == ST_HALT);
    assign illegal    = illegal_q;

endmodule
